// File: rtl/dot_product_sequencer_if.sv
// dot_product_sequencer_if
//   Handshake and adder bus for the dot-product sequencer.
//   Command: start/len in, busy out.
//   Term stream: in_valid/in_data in, in_ready out.
//   Adder: add_a/add_b out, add_sum in (combinational external adder).
//   Result: out_valid/out_data out, out_ready in.
//   Optional ovf (carry-out sticky flag) exists when DOT_OVF_FLAG_EN is defined.
//   master = environment side, slave = sequencer side.
interface dot_product_sequencer_if #(
    parameter int LEN_W  = 4,
    parameter int DATA_W = 18
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W-1:0] add_sum;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
`ifdef DOT_OVF_FLAG_EN
    logic              ovf;
`endif

    modport master (
        output start, len, in_valid, in_data, add_sum, out_ready,
`ifdef DOT_OVF_FLAG_EN
        input  ovf,
`endif
        input  busy, in_ready, add_a, add_b, out_valid, out_data
    );

    modport slave (
        input  start, len, in_valid, in_data, add_sum, out_ready,
`ifdef DOT_OVF_FLAG_EN
        output ovf,
`endif
        output busy, in_ready, add_a, add_b, out_valid, out_data
    );
endinterface

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
//   Accumulates one dot product from a stream of partial products using a
//   shared combinational adder (add_a = acc, add_b = in_data, add_sum back).
//   Ports: clk, rst_n (async active-low), bus (dot_product_sequencer_if.slave).
//   States: IDLE -> ACCUM (len terms, one per cycle) -> RESULT (hold until
//   out_ready). len==0 goes straight to RESULT with a zero result.
//   Optional macro DOT_OVF_FLAG_EN adds a sticky carry-out flag (bus.ovf).
module dot_product_sequencer #(
    parameter int LEN_W  = 4,
    parameter int DATA_W = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dot_product_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] acc_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              busy_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              accept_d;

    // in_ready_q is only high in ACCUM, so it doubles as the state qualifier.
    assign accept_d = in_ready_q & bus.in_valid;

    assign bus.add_a     = acc_q;
    assign bus.add_b     = bus.in_data;
    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;

`ifdef DOT_OVF_FLAG_EN
    logic ovf_q;
    assign bus.ovf = ovf_q;

    // Unsigned carry-out: the wrapped sum is smaller than the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && bus.start) begin
            ovf_q <= 1'b0;
        end else if (accept_d && (bus.add_sum < acc_q)) begin
            ovf_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q  <= '0;
                        busy_q <= 1'b1;
                        if (bus.len != '0) begin
                            cnt_q      <= bus.len;
                            in_ready_q <= 1'b1;
                            state_q    <= ACCUM;
                        end else begin
                            out_valid_q <= 1'b1;
                            state_q     <= RESULT;
                        end
                    end
                end
                ACCUM: begin
                    if (accept_d) begin
                        acc_q <= bus.add_sum;
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (bus.out_ready) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dot_product_sequencer.sv
module tb_dot_product_sequencer;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 18;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dot_product_sequencer_if #(.LEN_W(LEN_W), .DATA_W(DATA_W)) bus();

    // External combinational adder shared with the sequencer.
    assign bus.add_sum = bus.add_a + bus.add_b;

    dot_product_sequencer #(.LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string                  name;
        logic [LEN_W-1:0]       len;
        logic [3:0][DATA_W-1:0] terms;
        bit                     gap;
        int                     stall;
        logic [DATA_W-1:0]      exp_data;
        bit                     exp_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: start, stream terms (optionally gapped), stall the
    // result for 'stall' cycles, then handshake.
    task automatic run_txn(input vec_t v);
        int k;
        bit phase;
        bus.start = 1'b1;
        bus.len   = v.len;
        tick();
        bus.start = 1'b0;
        chk({v.name, "_busy_after_start"}, 32'(bus.busy), 32'd1);
        if (v.len == '0) begin
            chk({v.name, "_no_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        k = 0;
        phase = 1'b0;
        while (k < int'(v.len)) begin
            chk({v.name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
            chk({v.name, "_no_early_valid"}, 32'(bus.out_valid), 32'd0);
            if (v.gap && phase) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 18'h2AAAA;  // must not be consumed
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = v.terms[k];
                k++;
            end
            phase = ~phase;
            tick();
        end
        bus.in_valid = 1'b0;
        chk({v.name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({v.name, "_out_data"}, 32'(bus.out_data), 32'(v.exp_data));
        chk({v.name, "_in_ready_res"}, 32'(bus.in_ready), 32'd0);
`ifdef DOT_OVF_FLAG_EN
        chk({v.name, "_ovf"}, 32'(bus.ovf), 32'(v.exp_ovf));
`endif
        for (int s = 0; s < v.stall; s++) begin
            tick();
            chk({v.name, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
            chk({v.name, "_stall_data"}, 32'(bus.out_data), 32'(v.exp_data));
            chk({v.name, "_stall_busy"}, 32'(bus.busy), 32'd1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({v.name, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
        chk({v.name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        vec_t h;
        int   bound;
        checks = 0;
        failures = 0;

        vecs[0] = '{"b2b3",   4'd3, {18'd0, 18'd9, 18'd7, 18'd5}, 1'b0, 0, 18'd21,    1'b0};
        vecs[1] = '{"gap4",   4'd4, {18'd4, 18'd3, 18'd2, 18'd1}, 1'b1, 3, 18'd10,    1'b0};
        vecs[2] = '{"len0",   4'd0, {18'd0, 18'd0, 18'd0, 18'd0}, 1'b0, 1, 18'd0,     1'b0};
        vecs[3] = '{"wrap",   4'd2, {18'd0, 18'd0, 18'd2, 18'h3FFFF}, 1'b0, 0, 18'h00001, 1'b1};
        vecs[4] = '{"after",  4'd1, {18'd0, 18'd0, 18'd0, 18'd3}, 1'b0, 0, 18'd3,     1'b0};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_add_a",     32'(bus.add_a),     32'd0);
        rst_n = 1'b1;
        tick();

        // in_valid and out_ready in IDLE must be ignored.
        bus.in_valid  = 1'b1;
        bus.in_data   = 18'd77;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("idle_ignore_acc",   32'(bus.add_a),     32'd0);
        chk("idle_ignore_valid", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // start with a different len during ACCUM: ignored, len=3 completes.
        bus.start = 1'b1;
        bus.len   = 4'd3;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 18'd10;
        bus.len      = 4'd1;
        tick();
        bus.in_data = 18'd20;
        tick();
        bus.start   = 1'b0;
        chk("restart_still_accum", 32'(bus.out_valid), 32'd0);
        bus.in_data = 18'd30;
        tick();
        bus.in_valid = 1'b0;
        bound = 0;
        while (!bus.out_valid && bound < 10) begin
            tick();
            bound++;
        end
        chk("restart_valid_at_once", 32'(bound), 32'd0);
        chk("restart_sum", 32'(bus.out_data), 32'd60);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Async reset after 2 of 4 terms: outputs clear without a clock edge.
        bus.start = 1'b1;
        bus.len   = 4'd4;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 18'd1;
        tick();
        bus.in_data = 18'd2;
        tick();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",      32'(bus.busy),      32'd0);
        chk("arst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data",  32'(bus.out_data),  32'd0);
        chk("arst_add_a",     32'(bus.add_a),     32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        h = '{"post_rst", 4'd1, {18'd0, 18'd0, 18'd0, 18'd6}, 1'b0, 0, 18'd6, 1'b0};
        run_txn(h);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule
